muldiv_unit: RTL
================

# muldiv_unit

Parametrised multiply/divide unit for the EX stage of the five-stage pipeline. It owns the HI/LO registers and executes signed and unsigned multiply, divide, and optional multiply-accumulate operations with independently configurable latencies. It raises `busy` so the hazard unit can stall, and it drops an issue that coincides with an exception flush. It replaces the fixed-width, fixed-latency multiply/divide unit and adds MADD/MSUB and exception-aware issue.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width.
- `MUL_LAT`, 5: cycles `busy` stays high for multiply and multiply-accumulate ops. Must be ≥1.
- `DIV_LAT`, 10: cycles `busy` stays high for divide ops. Must be ≥1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: issue strobe, sampled at posedge.
- `op` in 4: operation code, from `muldiv_pkg`.
- `a` in WIDTH: rs operand.
- `b` in WIDTH: rt operand.
- `cancel` in 1: exception flush (CP0 Req); kills an issue in the same cycle.
- `hi` out WIDTH: HI register, read directly by mfhi.
- `lo` out WIDTH: LO register, read directly by mflo.
- `busy` out 1: registered; high while an op is in flight.

## Operation
- Op codes:
  - 0 NOP
  - 1 MULT
  - 2 MULTU
  - 3 DIV
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7 MADD
  - 8 MADDU
  - 9 MSUB
  - 10 MSUBU
  - 11–15 are treated as NOP.
- An issue is accepted when `start && !cancel && !busy`.
- `start` while `busy` is ignored. The pipeline never does this; the bench checks that the unit ignores it.
- States:
  - IDLE → RUN on an accepted MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU.
  - RUN → IDLE when the down-counter reaches 1.
- MTHI/MTLO write HI/LO at the accepting edge and do not enter RUN.
- Results are computed from the operands captured at the accepting edge and held in staging registers `pend_hi`/`pend_lo`. They are committed to HI/LO on the RUN → IDLE edge.
- Multiply: the full 2·WIDTH product, with HI taking the upper half.
- MADD/MSUB: {HI,LO} ± product, captured at the accept edge, wrapping modulo 2^(2·WIDTH).
- Divide:
  - LO = quotient, truncated toward zero.
  - HI = remainder, which takes the sign of the dividend.
  - The signed case −2^(WIDTH−1) / −1 gives LO = −2^(WIDTH−1), HI = 0.
- Divide by zero runs the full DIV_LAT cycles and leaves HI/LO unchanged.
- `cancel` during RUN has no effect: the in-flight op belongs to an older instruction and completes.
- Reset in any state returns to IDLE and clears HI, LO, `busy`, the counter and the staging registers.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0.
- Accepted long op at edge E0:
  - `busy` is high for exactly LAT cycles, from after E0 through E_LAT.
  - HI/LO take the new value at E_LAT, in the same edge where `busy` falls.
  - Back-to-back issue is legal in the cycle after `busy` falls.
- MTHI/MTLO: the new value is visible the cycle after the accept edge.
- `busy` is purely registered. The hazard unit must combine it with the ID-stage op for same-cycle stalls.
- Counter width is $clog2(max(MUL_LAT, DIV_LAT)+1).

## Configuration
- `MULDIV_MADD_EN` defined:
  - Ops 7–10 are implemented as above.
- `MULDIV_MADD_EN` undefined:
  - Ops 7–10 decode as NOP: no busy, HI/LO untouched.
  - The accumulate adder is not synthesised.

## Structure
- `muldiv_pkg` holds:
  - the 4-bit op enum `muldiv_op_t`;
  - the state enum;
  - the default latency localparams.
- This package is shared with the control unit's decoder.
- Single module with no sub-modules. The datapath is a combinational product/quotient feeding the staging registers, plus the counter FSM.

## Test plan
- MULT with a = 0xFFFFFFFD, b = 7 → `busy` high for 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIVU 100/7 → after 10 cycles lo = 14, hi = 2.
- DIV 0xFFFFFFF9 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- MTHI/MTLO to 0x12345678, then DIV by 0 → `busy` high for 10 cycles, hi and lo stay 0x12345678. 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- `start` together with `cancel` on MULT → `busy` stays 0, HI/LO unchanged. `cancel` at cycle 3 of a MULT → completes normally at cycle 5.
- hi = 0, lo = 0xFFFFFFFF, MADDU a = 1, b = 1 → hi = 1, lo = 0. Without the macro → no busy, values unchanged.
- `reset` asserted at cycle 4 of a DIV → next cycle `busy` = 0, hi = lo = 0, and no later commit occurs.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default latencies. Also imported by the control unit's decoder.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } muldiv_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } muldiv_state_t;

    localparam int MULDIV_WIDTH_DEF   = 32;
    localparam int MULDIV_MUL_LAT_DEF = 5;
    localparam int MULDIV_DIV_LAT_DEF = 10;

endpackage

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO, with latency-modelled busy.
// Define MULDIV_MADD_EN to implement MADD/MADDU/MSUB/MSUBU (otherwise NOP).
//
// state | meaning
// IDLE  | ready to accept an issue; MTHI/MTLO complete here
// RUN   | result staged in pend_*, counting down to commit
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = MULDIV_WIDTH_DEF,
    parameter int MUL_LAT = MULDIV_MUL_LAT_DEF,
    parameter int DIV_LAT = MULDIV_DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    muldiv_state_t      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   pend_hi_q, pend_lo_q;

    logic               accept;
    logic               long_op;
    logic [CNT_W-1:0]   lat_d;
    logic [2*WIDTH-1:0] pend_d;

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   a_mag, b_mag, uq_s, ur_s, q_s, r_s, q_u, r_u;
    logic               b_zero;

    assign accept = start && !cancel && !busy_q;

    // Signed divide works on magnitudes; the most-negative dividend's
    // magnitude still fits as an unsigned value, so -MIN/-1 wraps to MIN.
    always_comb begin
        a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
        b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
        a_zx   = {{WIDTH{1'b0}}, a};
        b_zx   = {{WIDTH{1'b0}}, b};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;
        b_zero = (b == '0);
        a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
        b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
        uq_s   = b_zero ? '0 : a_mag / b_mag;
        ur_s   = b_zero ? '0 : a_mag % b_mag;
        q_s    = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~uq_s + 1'b1) : uq_s;
        r_s    = a[WIDTH-1] ? (~ur_s + 1'b1) : ur_s;
        q_u    = b_zero ? '0 : a / b;
        r_u    = b_zero ? '0 : a % b;
    end

    // A divide by zero stages the current HI/LO so the commit is a no-op.
    always_comb begin
        long_op = 1'b0;
        lat_d   = CNT_W'(MUL_LAT);
        pend_d  = {hi_q, lo_q};
        case (op)
            OP_MULT:  begin long_op = 1'b1; pend_d = prod_s; end
            OP_MULTU: begin long_op = 1'b1; pend_d = prod_u; end
            OP_DIV: begin
                long_op = 1'b1;
                lat_d   = CNT_W'(DIV_LAT);
                if (!b_zero) pend_d = {r_s, q_s};
            end
            OP_DIVU: begin
                long_op = 1'b1;
                lat_d   = CNT_W'(DIV_LAT);
                if (!b_zero) pend_d = {r_u, q_u};
            end
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin long_op = 1'b1; pend_d = {hi_q, lo_q} + prod_s; end
            OP_MADDU: begin long_op = 1'b1; pend_d = {hi_q, lo_q} + prod_u; end
            OP_MSUB:  begin long_op = 1'b1; pend_d = {hi_q, lo_q} - prod_s; end
            OP_MSUBU: begin long_op = 1'b1; pend_d = {hi_q, lo_q} - prod_u; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) hi_q <= a;
                        if (op == OP_MTLO) lo_q <= a;
                        if (long_op) begin
                            state_q                <= ST_RUN;
                            busy_q                 <= 1'b1;
                            cnt_q                  <= lat_d;
                            {pend_hi_q, pend_lo_q} <= pend_d;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;

endmodule
